keypad_scanner: RTL and testbench
=================================

// Module: keypad_scanner
// PURPOSE
//   Scans a 4x4 active-low matrix keypad, synchronises and debounces the row lines,
//   and decodes each clean keypress into the one-cycle command strobes consumed by
//   gencon: keypad_input/read_input, operator_input, equal_input.
//   Sits directly upstream of gencon; all outputs are in the clk domain.
// PARAMETERS
//   SCAN_DIV        1000   clk cycles each column is driven before its rows are sampled; must be >= SYNC_STAGES+1
//   DEBOUNCE_CYCLES 20000  consecutive stable synchronised cycles needed to accept a press or a release
//   SYNC_STAGES     2      flop depth of the row_in synchroniser
// PORTS
//   clk             in   1  system clock, rising edge
//   nRST            in   1  asynchronous active-low reset
//   row_in          in   4  keypad rows, active-low, externally pulled up, asynchronous
//   col_out         out  4  keypad column drive, active-low, exactly one bit low at a time
//   keypad_input    out  4  last accepted digit 0-9; updated with read_input, then held
//   read_input      out  1  one-cycle strobe: new digit on keypad_input
//   operator_input  out  3  one-cycle operator code, 3'b000 otherwise
//   equal_input     out  1  one-cycle strobe for '#'
//   clear_input     out  1  one-cycle strobe for '*'
// BEHAVIOUR
//   Reset (async assert, sync release)
//     - state SCAN, column 0 selected, col_out=4'b1110
//     - keypad_input=0; all strobes 0; all counters 0; synchroniser flops set to 4'hF
//   Key map (row r, col c)
//     - r0: 1 2 3 A | r1: 4 5 6 B | r2: 7 8 9 C | r3: * 0 # D
//     - A->op 3'b001 (negate), B->3'b010 (add), C->3'b011 (sub), D->3'b100 (mul)
//   Synchronised rows: rs = row_in after SYNC_STAGES flops. "Pressed" = any rs bit low.
//   FSM
//   - SCAN:
//     - div counter runs 0..SCAN_DIV-1
//     - at count SCAN_DIV-1: exactly one rs bit low -> latch (row,col), go DEBOUNCE, column frozen
//     - more than one rs bit low -> go WAIT_RELEASE, no output
//     - no rs bit low -> advance column (3 wraps to 0), counter restarts
//   - DEBOUNCE:
//     - counter increments each cycle rs equals the latched one-hot pattern
//     - any mismatch -> back to SCAN, counter cleared, same column, no output
//     - count reaches DEBOUNCE_CYCLES -> EMIT
//   - EMIT (exactly one cycle):
//     - assert the decoded strobe, registered
//     - digit also loads keypad_input; go WAIT_RELEASE
//   - WAIT_RELEASE:
//     - column stays frozen
//     - counter increments while rs==4'hF and clears on any low bit
//     - reaches DEBOUNCE_CYCLES -> SCAN
//   Outputs
//     - at most one strobe high in any cycle
//     - strobes never high outside EMIT
//     - exactly one strobe per physical press regardless of hold time or bounce
//     - keypad_input never changes except in EMIT for a digit key
//   Latency
//     - strobe appears in the cycle after the DEBOUNCE_CYCLES-th stable DEBOUNCE cycle
//     - worst-case detection adds 4*SCAN_DIV + SYNC_STAGES cycles
//   Boundaries
//     - release shorter than DEBOUNCE_CYCLES while in WAIT_RELEASE: no second strobe
//     - reset mid-DEBOUNCE/EMIT: no strobe; a key still held after reset needs a full fresh scan + debounce
//     - widths: all counters sized $clog2(param+1); no wrap in DEBOUNCE/WAIT_RELEASE
// TESTING (SCAN_DIV=4, DEBOUNCE_CYCLES=8; keypad model pulls row r low when col_out[c]==0 and key (r,c) held)
//   1. Hold '7' for 60 cycles, then release
//      -> exactly one read_input pulse, keypad_input=4'd7 held after release
//      -> col_out resumes rotating 1110,1101,1011,0111 only after 8 released cycles
//   2. Bounce '5' (toggle every 3 cycles for 24 cycles), then hold
//      -> exactly one read_input, keypad_input=5, no spurious strobes during bounce
//   3. Press 'D', then '#', then '*'
//      -> operator_input=3'b100 for one cycle then 3'b000
//      -> equal_input high one cycle; clear_input high one cycle
//   4. Hold '1' and '4' together (same column)
//      -> no strobe; after both released 8 cycles, scanning resumes; pressing '4' alone yields keypad_input=4
//   5. Hold '9', pull nRST low during DEBOUNCE for 2 cycles
//      -> outputs 0 and col_out=4'b1110 immediately; exactly one read_input after a fresh scan+8 stable cycles
//   6. Hold 'B', release for 5 cycles, re-press, then release fully
//      -> only one operator_input=3'b010 strobe; a later distinct press of 'B' strobes again

Source files
------------

// File: rtl/keypad_scanner.sv
// 4x4 active-low matrix keypad scanner: column drive, row synchroniser, press/release
// debounce and decode into one-cycle command strobes for gencon.
module keypad_scanner #(
    parameter int SCAN_DIV        = 1000,
    parameter int DEBOUNCE_CYCLES = 20000,
    parameter int SYNC_STAGES     = 2
) (
    input  logic       clk,
    input  logic       nRST,
    input  logic [3:0] row_in,
    output logic [3:0] col_out,
    output logic [3:0] keypad_input,
    output logic       read_input,
    output logic [2:0] operator_input,
    output logic       equal_input,
    output logic       clear_input,
    output logic [1:0] state_dbg
);

    localparam int DIV_W = $clog2(SCAN_DIV + 1);
    localparam int DEB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [DEB_W-1:0] DEB_DONE = DEB_W'(DEBOUNCE_CYCLES);

    typedef enum logic [1:0] {
        SCAN         = 2'd0,
        DEBOUNCE     = 2'd1,
        EMIT         = 2'd2,
        WAIT_RELEASE = 2'd3
    } state_t;

    state_t           state, state_d;
    logic [DIV_W-1:0] div_cnt, div_d;
    logic [DEB_W-1:0] deb_cnt, deb_d, deb_inc;
    logic [1:0]       col_idx, col_d;
    logic [1:0]       row_idx, row_idx_d;
    logic [3:0]       key_d;
    logic             read_d, eq_d, clr_d;
    logic [2:0]       op_d;

    logic [3:0] sync_q [SYNC_STAGES];
    logic [3:0] rs;
    logic [3:0] row_pat;
    logic       one_low, any_low, released;

    // Row lines are asynchronous; idle value is all-high so reset loads 4'hF.
    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= 4'hF;
        end else begin
            sync_q[0] <= row_in;
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
    end

    assign rs       = sync_q[SYNC_STAGES-1];
    assign one_low  = (rs == 4'b1110) || (rs == 4'b1101) || (rs == 4'b1011) || (rs == 4'b0111);
    assign any_low  = (rs != 4'hF);
    assign released = (rs == 4'hF);
    assign row_pat  = ~(4'b0001 << row_idx);
    assign deb_inc  = deb_cnt + 1'b1;
    assign col_out  = ~(4'b0001 << col_idx);
    assign state_dbg = state;

    function automatic logic [1:0] low_index(input logic [3:0] p);
        case (p)
            4'b1110: return 2'd0;
            4'b1101: return 2'd1;
            4'b1011: return 2'd2;
            default: return 2'd3;
        endcase
    endfunction

    // Key decode from the latched (row, col): column 3 holds the operators A-D.
    logic       dec_digit, dec_eq, dec_clr;
    logic [3:0] dec_val;
    logic [2:0] dec_op;

    always_comb begin
        dec_digit = 1'b0;
        dec_val   = 4'd0;
        dec_op    = 3'd0;
        dec_eq    = 1'b0;
        dec_clr   = 1'b0;
        if (col_idx == 2'd3) begin
            dec_op = {1'b0, row_idx} + 3'd1;
        end else if (row_idx != 2'd3) begin
            dec_digit = 1'b1;
            dec_val   = 4'(row_idx) * 4'd3 + 4'(col_idx) + 4'd1;
        end else begin
            case (col_idx)
                2'd0:    dec_clr = 1'b1;
                2'd1:    dec_digit = 1'b1;
                default: dec_eq = 1'b1;
            endcase
        end
    end

    always_comb begin
        state_d   = state;
        div_d     = div_cnt;
        deb_d     = deb_cnt;
        col_d     = col_idx;
        row_idx_d = row_idx;
        key_d     = keypad_input;
        read_d    = 1'b0;
        op_d      = 3'd0;
        eq_d      = 1'b0;
        clr_d     = 1'b0;
        case (state)
            SCAN: begin
                if (div_cnt == DIV_LAST) begin
                    div_d = '0;
                    if (one_low) begin
                        state_d   = DEBOUNCE;
                        row_idx_d = low_index(rs);
                        deb_d     = '0;
                    end else if (any_low) begin
                        state_d = WAIT_RELEASE;
                        deb_d   = '0;
                    end else begin
                        col_d = col_idx + 2'd1;
                    end
                end else begin
                    div_d = div_cnt + 1'b1;
                end
            end
            DEBOUNCE: begin
                if (rs == row_pat) begin
                    deb_d = deb_inc;
                    // Strobes are loaded on the way into EMIT so they are high exactly while in EMIT.
                    if (deb_inc == DEB_DONE) begin
                        state_d = EMIT;
                        read_d  = dec_digit;
                        op_d    = dec_op;
                        eq_d    = dec_eq;
                        clr_d   = dec_clr;
                        if (dec_digit) key_d = dec_val;
                    end
                end else begin
                    state_d = SCAN;
                    deb_d   = '0;
                    div_d   = '0;
                end
            end
            EMIT: begin
                state_d = WAIT_RELEASE;
                deb_d   = '0;
            end
            WAIT_RELEASE: begin
                if (released) begin
                    deb_d = deb_inc;
                    if (deb_inc == DEB_DONE) begin
                        state_d = SCAN;
                        deb_d   = '0;
                        div_d   = '0;
                    end
                end else begin
                    deb_d = '0;
                end
            end
            default: state_d = SCAN;
        endcase
    end

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            state          <= SCAN;
            div_cnt        <= '0;
            deb_cnt        <= '0;
            col_idx        <= 2'd0;
            row_idx        <= 2'd0;
            keypad_input   <= 4'd0;
            read_input     <= 1'b0;
            operator_input <= 3'd0;
            equal_input    <= 1'b0;
            clear_input    <= 1'b0;
        end else begin
            state          <= state_d;
            div_cnt        <= div_d;
            deb_cnt        <= deb_d;
            col_idx        <= col_d;
            row_idx        <= row_idx_d;
            keypad_input   <= key_d;
            read_input     <= read_d;
            operator_input <= op_d;
            equal_input    <= eq_d;
            clear_input    <= clr_d;
        end
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with a behavioural keypad matrix model
// (SCAN_DIV=4, DEBOUNCE_CYCLES=8).
module tb_keypad_scanner;

    logic       clk = 1'b0;
    logic       nRST = 1'b0;
    logic [3:0] row_in;
    logic [3:0] col_out;
    logic [3:0] keypad_input;
    logic       read_input;
    logic [2:0] operator_input;
    logic       equal_input;
    logic       clear_input;
    logic [1:0] state_dbg;

    localparam logic [1:0] ST_DEBOUNCE = 2'd1;

    keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE_CYCLES(8), .SYNC_STAGES(2)) dut (
        .clk(clk), .nRST(nRST), .row_in(row_in), .col_out(col_out),
        .keypad_input(keypad_input), .read_input(read_input),
        .operator_input(operator_input), .equal_input(equal_input),
        .clear_input(clear_input), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    // held[r*4+c]: key (r,c) is physically down; it pulls row r low while column c is driven.
    logic [15:0] held = '0;
    always_comb begin
        row_in = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (held[r*4+c] && !col_out[c]) row_in[r] = 1'b0;
    end

    int checks = 0;
    int failures = 0;
    int n_read = 0, n_op = 0, n_eq = 0, n_clr = 0, n_multi = 0;
    logic [2:0] last_op = 3'd0;

    always @(negedge clk) begin
        if (nRST) begin
            n_read += int'(read_input);
            n_eq   += int'(equal_input);
            n_clr  += int'(clear_input);
            if (operator_input != 3'd0) begin
                n_op++;
                last_op = operator_input;
            end
            if (int'(read_input) + int'(operator_input != 3'd0) + int'(equal_input) + int'(clear_input) > 1)
                n_multi++;
        end
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic press_release(input int idx, input int hold, input int rel);
        held[idx] = 1'b1;
        repeat (hold) @(negedge clk);
        held[idx] = 1'b0;
        repeat (rel) @(negedge clk);
    endtask

    typedef struct {
        int         r;
        int         c;
        int         exp_read;
        int         exp_op_cnt;
        int         exp_op;
        int         exp_eq;
        int         exp_clr;
        int         exp_key;
    } vec_t;

    vec_t vecs[9];

    initial begin
        int b_read, b_op, b_eq, b_clr, bad, k, found;
        logic [3:0] prev;
        logic [3:0] got[3];

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_col_out", int'(col_out), 14);
        check("rst_keypad", int'(keypad_input), 0);
        check("rst_strobes", int'({read_input, operator_input, equal_input, clear_input}), 0);
        nRST = 1'b1;
        repeat (4) @(negedge clk);

        // Hold '7' then release: one strobe, column frozen until release is debounced
        b_read = n_read;
        held[8] = 1'b1;
        repeat (60) @(negedge clk);
        held[8] = 1'b0;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (col_out != 4'b1110) bad++;
        end
        check("t1_col_frozen", bad, 0);
        for (int i = 0; i < 3; i++) got[i] = 4'h0;
        prev = col_out;
        k = 0;
        for (int i = 0; i < 40 && k < 3; i++) begin
            @(negedge clk);
            if (col_out != prev) begin
                got[k] = col_out;
                k++;
                prev = col_out;
            end
        end
        check("t1_rotate0", int'(got[0]), 13);
        check("t1_rotate1", int'(got[1]), 11);
        check("t1_rotate2", int'(got[2]), 7);
        check("t1_reads", n_read - b_read, 1);
        check("t1_keypad", int'(keypad_input), 7);

        // Single-key table: D # * 0 3 A C 6 8
        vecs[0] = '{3, 3, 0, 1, 4, 0, 0, 7};
        vecs[1] = '{3, 2, 0, 0, 0, 1, 0, 7};
        vecs[2] = '{3, 0, 0, 0, 0, 0, 1, 7};
        vecs[3] = '{3, 1, 1, 0, 0, 0, 0, 0};
        vecs[4] = '{0, 2, 1, 0, 0, 0, 0, 3};
        vecs[5] = '{0, 3, 0, 1, 1, 0, 0, 3};
        vecs[6] = '{2, 3, 0, 1, 3, 0, 0, 3};
        vecs[7] = '{1, 2, 1, 0, 0, 0, 0, 6};
        vecs[8] = '{2, 1, 1, 0, 0, 0, 0, 8};
        for (int v = 0; v < 9; v++) begin
            b_read = n_read; b_op = n_op; b_eq = n_eq; b_clr = n_clr;
            press_release(vecs[v].r * 4 + vecs[v].c, 60, 30);
            check($sformatf("vec%0d_read", v), n_read - b_read, vecs[v].exp_read);
            check($sformatf("vec%0d_op_cycles", v), n_op - b_op, vecs[v].exp_op_cnt);
            check($sformatf("vec%0d_eq", v), n_eq - b_eq, vecs[v].exp_eq);
            check($sformatf("vec%0d_clr", v), n_clr - b_clr, vecs[v].exp_clr);
            check($sformatf("vec%0d_keypad", v), int'(keypad_input), vecs[v].exp_key);
            if (vecs[v].exp_op_cnt != 0)
                check($sformatf("vec%0d_op_code", v), int'(last_op), vecs[v].exp_op);
            check($sformatf("vec%0d_op_idle", v), int'(operator_input), 0);
        end

        // Bounce '5' every 3 cycles, then hold
        b_read = n_read; b_op = n_op; b_eq = n_eq; b_clr = n_clr;
        for (int i = 0; i < 8; i++) begin
            held[5] = ~held[5];
            repeat (3) @(negedge clk);
        end
        check("t2_no_strobe_bounce", (n_read - b_read) + (n_op - b_op) + (n_eq - b_eq) + (n_clr - b_clr), 0);
        press_release(5, 60, 30);
        check("t2_reads", n_read - b_read, 1);
        check("t2_keypad", int'(keypad_input), 5);

        // '1' and '4' together in column 0: no strobe, then '4' alone
        b_read = n_read; b_op = n_op; b_eq = n_eq; b_clr = n_clr;
        held[0] = 1'b1;
        held[4] = 1'b1;
        repeat (60) @(negedge clk);
        held[0] = 1'b0;
        held[4] = 1'b0;
        repeat (30) @(negedge clk);
        check("t4_no_strobe", (n_read - b_read) + (n_op - b_op) + (n_eq - b_eq) + (n_clr - b_clr), 0);
        check("t4_keypad_held", int'(keypad_input), 5);
        press_release(4, 60, 30);
        check("t4_reads", n_read - b_read, 1);
        check("t4_keypad", int'(keypad_input), 4);

        // Reset in the middle of debouncing '9'
        b_read = n_read;
        held[10] = 1'b1;
        found = 0;
        for (int i = 0; i < 100 && found == 0; i++) begin
            @(negedge clk);
            if (state_dbg == ST_DEBOUNCE) found = 1;
        end
        check("t5_reach_debounce", found, 1);
        repeat (3) @(negedge clk);
        check("t5_no_strobe_pre", n_read - b_read, 0);
        nRST = 1'b0;
        #1;
        check("t5_rst_col_out", int'(col_out), 14);
        check("t5_rst_keypad", int'(keypad_input), 0);
        check("t5_rst_strobes", int'({read_input, operator_input, equal_input, clear_input}), 0);
        repeat (2) @(negedge clk);
        nRST = 1'b1;
        b_read = n_read;
        repeat (60) @(negedge clk);
        held[10] = 1'b0;
        repeat (30) @(negedge clk);
        check("t5_reads", n_read - b_read, 1);
        check("t5_keypad", int'(keypad_input), 9);

        // 'B' with a short release gap counts once; a later press counts again
        b_op = n_op;
        held[7] = 1'b1;
        repeat (40) @(negedge clk);
        held[7] = 1'b0;
        repeat (5) @(negedge clk);
        held[7] = 1'b1;
        repeat (40) @(negedge clk);
        held[7] = 1'b0;
        repeat (30) @(negedge clk);
        check("t6_op_once", n_op - b_op, 1);
        check("t6_op_code", int'(last_op), 2);
        b_op = n_op;
        last_op = 3'd0;
        press_release(7, 60, 30);
        check("t6_op_again", n_op - b_op, 1);
        check("t6_op_code2", int'(last_op), 2);

        check("one_strobe_per_cycle", n_multi, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
